// File: rtl/store_write_buffer_pkg.sv
// Shared constants for the store write buffer: drain FSM state encodings and
// default geometry.
package store_write_buffer_pkg;

  localparam int SWB_DEPTH  = 4;
  localparam int SWB_ADDR_W = 32;
  localparam int SWB_DATA_W = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/store_write_buffer_fifo.sv
// swb_fifo: in-order store storage with head/tail pointers and an occupancy count.
// With STORE_WRITE_BUFFER_FWD_EN the raw entries and head pointer are exported.
module swb_fifo
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
`ifdef STORE_WRITE_BUFFER_FWD_EN
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
  output logic [PTR_W-1:0]               ent_head,
`endif
  output logic [CNT_W-1:0]               count,
  output logic [CNT_W-1:0]               count_next,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [DATA_W-1:0]              head_data
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem_q, addr_mem_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;
  logic                         full_s, empty_s, push_ok_s, pop_ok_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CNT_W{1'b0}});

  // Next-state for pointers, count and storage; refuses overflow/underflow.
  always_comb begin
    push_ok_s  = push & ~full_s;
    pop_ok_s   = pop & ~empty_s;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push_ok_s) begin
      addr_mem_d[tail_q] = push_addr;
      data_mem_d[tail_q] = push_data;
      tail_d             = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_ok_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      addr_mem_q <= {(DEPTH*ADDR_W){1'b0}};
      data_mem_q <= {(DEPTH*DATA_W){1'b0}};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign head_addr  = addr_mem_q[head_q];
  assign head_data  = data_mem_q[head_q];
`ifdef STORE_WRITE_BUFFER_FWD_EN
  assign ent_addr   = addr_mem_q;
  assign ent_data   = data_mem_q;
  assign ent_head   = head_q;
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: accepts committed stores and drains them in order to memory.
// Optional store-to-load forwarding is enabled by defining STORE_WRITE_BUFFER_FWD_EN.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cacheWriteEnable,
  input  logic [ADDR_W-1:0] cacheWriteAddr,
  input  logic [DATA_W-1:0] cacheWriteData,
  output logic              cacheWriteDone,
  output logic              memWriteReq,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [DATA_W-1:0] memWriteData,
  input  logic              memWriteAck,
`ifdef STORE_WRITE_BUFFER_FWD_EN
  input  logic [ADDR_W-1:0] loadQueryAddr,
  output logic              loadQueryHit,
  output logic [DATA_W-1:0] loadQueryData,
`endif
  output logic              bufferEmpty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [0:0]        state_q, state_d;
  logic              req_q, req_d, done_q, done_d, empty_q, empty_d;
  logic [ADDR_W-1:0] addr_q, addr_d, head_addr_s;
  logic [DATA_W-1:0] data_q, data_d, head_data_s;
  logic [CNT_W-1:0]  count_s, count_next_s;
  logic              push_s, pop_s;

`ifdef STORE_WRITE_BUFFER_FWD_EN
  localparam int PTR_W = $clog2(DEPTH);
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_s;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data_s;
  logic [PTR_W-1:0]             ent_head_s;
`endif

  swb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_addr  (cacheWriteAddr),
    .push_data  (cacheWriteData),
    .pop        (pop_s),
`ifdef STORE_WRITE_BUFFER_FWD_EN
    .ent_addr   (ent_addr_s),
    .ent_data   (ent_data_s),
    .ent_head   (ent_head_s),
`endif
    .count      (count_s),
    .count_next (count_next_s),
    .head_addr  (head_addr_s),
    .head_data  (head_data_s)
  );

  // Drain FSM and next values of the registered status outputs.
  always_comb begin
    push_s  = cacheWriteEnable & done_q;
    pop_s   = (state_q == ST_REQ) & memWriteAck;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        // Address/data are captured once here so later pushes cannot disturb them.
        if (count_s != {CNT_W{1'b0}}) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = head_addr_s;
          data_d  = head_data_s;
        end else begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (memWriteAck) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
    done_d  = (count_next_s < DEPTH_C);
    empty_d = (count_next_s == {CNT_W{1'b0}}) && (state_d == ST_IDLE);
  end

  // Registered FSM state and outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      done_q  <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      empty_q <= empty_d;
    end
  end

  assign cacheWriteDone = done_q;
  assign memWriteReq    = req_q;
  assign memWriteAddr   = addr_q;
  assign memWriteData   = data_q;
  assign bufferEmpty    = empty_q;

`ifdef STORE_WRITE_BUFFER_FWD_EN
  logic [PTR_W-1:0] fwd_idx_s;

  // Oldest-to-youngest scan so the youngest matching entry wins.
  always_comb begin
    loadQueryHit  = 1'b0;
    loadQueryData = {DATA_W{1'b0}};
    fwd_idx_s     = ent_head_s;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = ent_head_s + PTR_W'(i);
      if ((CNT_W'(i) < count_s) && (ent_addr_s[fwd_idx_s] == loadQueryAddr)) begin
        loadQueryHit  = 1'b1;
        loadQueryData = ent_data_s[fwd_idx_s];
      end else begin
        loadQueryHit  = loadQueryHit;
        loadQueryData = loadQueryData;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: queue-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, cacheWriteEnable, cacheWriteDone, memWriteReq, memWriteAck, bufferEmpty;
  logic [31:0] cacheWriteAddr, cacheWriteData, memWriteAddr, memWriteData;
`ifdef STORE_WRITE_BUFFER_FWD_EN
  logic [31:0] loadQueryAddr, loadQueryData;
  logic        loadQueryHit;
`endif

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cacheWriteEnable(cacheWriteEnable), .cacheWriteAddr(cacheWriteAddr),
    .cacheWriteData(cacheWriteData), .cacheWriteDone(cacheWriteDone),
    .memWriteReq(memWriteReq), .memWriteAddr(memWriteAddr), .memWriteData(memWriteData),
    .memWriteAck(memWriteAck),
`ifdef STORE_WRITE_BUFFER_FWD_EN
    .loadQueryAddr(loadQueryAddr), .loadQueryHit(loadQueryHit), .loadQueryData(loadQueryData),
`endif
    .bufferEmpty(bufferEmpty)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: pending stores as a queue (head = in-flight store).
  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [63:0] mlog[$];
  bit          m_req, m_done, m_empty, chk_en, popped, pushed;
  logic [31:0] m_addr, m_data;
  int          old_sz;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_req = 1'b0; m_addr = 32'h0; m_data = 32'h0; m_done = 1'b1; m_empty = 1'b1;
    end else begin
      old_sz = mq.size();
      popped = m_req && memWriteAck;
      pushed = cacheWriteEnable && m_done;
      if (popped) mq.delete(0);
      if (pushed) mq.push_back({cacheWriteAddr, cacheWriteData});
      if (popped) m_req = 1'b0;
      else if (!m_req && old_sz > 0) begin
        m_req = 1'b1; m_addr = mq[0].a; m_data = mq[0].d;
      end
      m_done  = mq.size() < DEPTH;
      m_empty = (mq.size() == 0) && !m_req;
    end
  end

  // Per-cycle compare against the model, and log of writes memory accepts.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_done", cacheWriteDone, m_done);
      chk("model_empty", bufferEmpty, m_empty);
      chk("model_req", memWriteReq, m_req);
      chk("model_addr", memWriteAddr, m_addr);
      chk("model_data", memWriteData, m_data);
`ifdef STORE_WRITE_BUFFER_FWD_EN
      begin
        logic        eh;
        logic [31:0] ed;
        eh = 1'b0; ed = 32'h0;
        foreach (mq[i]) if (mq[i].a == loadQueryAddr) begin eh = 1'b1; ed = mq[i].d; end
        chk("model_fwd_hit", loadQueryHit, eh);
        chk("model_fwd_data", loadQueryData, ed);
      end
`endif
    end
    if (rst_n === 1'b1 && memWriteReq === 1'b1 && memWriteAck === 1'b1)
      mlog.push_back({memWriteAddr, memWriteData});
  end

  // Memory ack responder. Mode 0: low, 1: random 0..max_delay wait, 2: held high.
  int ack_mode = 0, max_delay = 0, wait_cnt = 0;
  initial begin
    memWriteAck = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: memWriteAck = 1'b0;
        2: memWriteAck = 1'b1;
        default: begin
          if (memWriteReq && !memWriteAck) begin
            if (wait_cnt == 0) begin
              memWriteAck = 1'b1;
              wait_cnt = $urandom_range(0, max_delay);
            end else wait_cnt--;
          end else memWriteAck = 1'b0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bit acc;
    int n;
    cacheWriteEnable = 1'b1; cacheWriteAddr = a; cacheWriteData = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = cacheWriteDone;
      tick();
      n++;
    end
    cacheWriteEnable = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (!bufferEmpty && n < budget) begin tick(); n++; end
    chk("drain_timeout", bufferEmpty, 1'b1);
  endtask

  logic [63:0] exp_w[10];

  initial begin
    rst_n = 1'b0; cacheWriteEnable = 1'b0; cacheWriteAddr = 32'h0; cacheWriteData = 32'h0;
    chk_en = 1'b0;
`ifdef STORE_WRITE_BUFFER_FWD_EN
    loadQueryAddr = 32'h0;
`endif
    tick(); chk_en = 1'b1;
    tick();
    chk("rst_done", cacheWriteDone, 1'b1);
    chk("rst_empty", bufferEmpty, 1'b1);
    chk("rst_req", memWriteReq, 1'b0);
    chk("rst_addr", memWriteAddr, 32'h0);
    rst_n = 1'b1;

    // single store, ack held high
    ack_mode = 2; tick();
    push(32'h10, 32'hDEADBEEF);
    chk("t1_req_before", memWriteReq, 1'b0);
    tick();
    chk("t1_req", memWriteReq, 1'b1);
    chk("t1_addr", memWriteAddr, 32'h10);
    chk("t1_data", memWriteData, 32'hDEADBEEF);
    tick();
    chk("t1_empty", bufferEmpty, 1'b1);
    chk("t1_log", mlog.size(), 1);
    if (mlog.size() > 0) chk("t1_logv", mlog[0], {32'h10, 32'hDEADBEEF});

    // fill, ignored 5th, ordered drain
    ack_mode = 0; tick(); mlog.delete();
    for (int i = 0; i < 4; i++) push(32'h40 + i, 32'hA0 + i);
    chk("t2_full_done", cacheWriteDone, 1'b0);
    cacheWriteEnable = 1'b1; cacheWriteAddr = 32'h55; cacheWriteData = 32'h5555;
    tick(); tick();
    cacheWriteEnable = 1'b0;
    chk("t2_still_full", cacheWriteDone, 1'b0);
    ack_mode = 1; max_delay = 0; wait_cnt = 0;
    wait_empty(100);
    chk("t2_log_n", mlog.size(), 4);
    for (int i = 0; i < 4 && i < mlog.size(); i++)
      chk("t2_order", mlog[i], {32'h40 + i, 32'hA0 + i});

    // push attempted on the pop edge while full; ROB retries
    ack_mode = 0; tick(); mlog.delete();
    for (int i = 0; i < 4; i++) push(32'h60 + i, 32'hC0000000 + i);
    chk("t3_full", cacheWriteDone, 1'b0);
    ack_mode = 2; tick();
    cacheWriteEnable = 1'b1; cacheWriteAddr = 32'h99; cacheWriteData = 32'h9999;
    ack_mode = 0;
    tick();
    chk("t3_done_after_pop", cacheWriteDone, 1'b1);
    tick();
    cacheWriteEnable = 1'b0;
    chk("t3_refull", cacheWriteDone, 1'b0);
    ack_mode = 1; max_delay = 0; wait_cnt = 0;
    wait_empty(100);
    chk("t3_log_n", mlog.size(), 5);
    for (int i = 0; i < 4 && i < mlog.size(); i++)
      chk("t3_order", mlog[i], {32'h60 + i, 32'hC0000000 + i});
    if (mlog.size() == 5) chk("t3_last", mlog[4], {32'h99, 32'h9999});

    // tail wrap with random ack latency
    tick(); mlog.delete(); max_delay = 3; wait_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      exp_w[i] = {32'h100 + 32'(i * 4), $urandom()};
      push(exp_w[i][63:32], exp_w[i][31:0]);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_empty(300);
    chk("t4_log_n", mlog.size(), 10);
    for (int i = 0; i < 10 && i < mlog.size(); i++) chk("t4_order", mlog[i], exp_w[i]);

    // reset while a request is outstanding
    ack_mode = 0; tick(); mlog.delete();
    for (int i = 0; i < 3; i++) push(32'h70 + i, 32'h700 + i);
    chk("t5_req", memWriteReq, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_req_drop", memWriteReq, 1'b0);
    chk("t5_done", cacheWriteDone, 1'b1);
    chk("t5_empty", bufferEmpty, 1'b1);
    ack_mode = 2; tick(); tick(); tick();
    chk("t5_late_ack_req", memWriteReq, 1'b0);
    chk("t5_late_ack_empty", bufferEmpty, 1'b1);
    chk("t5_no_write", mlog.size(), 0);
    ack_mode = 0; tick();

`ifdef STORE_WRITE_BUFFER_FWD_EN
    // forwarding: youngest match wins, in-flight head included
    push(32'h20, 32'h1);
    push(32'h20, 32'h2);
    loadQueryAddr = 32'h20; #1;
    chk("t6_hit", loadQueryHit, 1'b1);
    chk("t6_data", loadQueryData, 32'h2);
    loadQueryAddr = 32'h24; #1;
    chk("t6_miss", loadQueryHit, 1'b0);
    chk("t6_miss_data", loadQueryData, 32'h0);
    ack_mode = 1; max_delay = 0; wait_cnt = 0;
    wait_empty(100);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
